// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: round-robin arbiter for two cell writers plus a full-grid clear engine.
// Define VBLANK_ONLY_EN to issue grants and clear writes only while iVBLANK=1.
module fb_write_scheduler #(
    parameter int GRID_W = 20,
    parameter int GRID_H = 15
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iREQ0,
    input  logic        iREQ1,
    input  logic [6:0]  iX0,
    input  logic [6:0]  iX1,
    input  logic [5:0]  iY0,
    input  logic [5:0]  iY1,
    input  logic [11:0] iD0,
    input  logic [11:0] iD1,
    input  logic        iCLEAR,
    input  logic [11:0] iCLEAR_DATA,
    input  logic        iVBLANK,
    output logic        oGNT0,
    output logic        oGNT1,
    output logic        oUPDATE_EN,
    output logic [6:0]  oUPDATE_X,
    output logic [5:0]  oUPDATE_Y,
    output logic [11:0] oUPDATE_DATA,
    output logic        oBUSY,
    output logic        oCLEAR_DONE
);
    typedef enum logic [1:0] {IDLE, CLEAR, FINISH} state_t;
    state_t state, state_n;
    logic [6:0] cx, cx_n, x_n;
    logic [5:0] cy, cy_n, y_n;
    logic [11:0] clr, clr_n, data_n;
    logic ptr, ptr_n, gnt0_n, gnt1_n, en_n, slot, e0, e1, row_end;
`ifdef VBLANK_ONLY_EN
    assign slot = iVBLANK;
`else
    assign slot = iVBLANK | 1'b1;
`endif
    // A requester granted this cycle still holds its request; skip it once.
    assign e0 = iREQ0 & ~oGNT0 & slot;
    assign e1 = iREQ1 & ~oGNT1 & slot;
    assign row_end = cx == 7'(GRID_W - 1);
    always_comb begin
        state_n = state;
        cx_n = cx;
        cy_n = cy;
        clr_n = clr;
        ptr_n = ptr;
        gnt0_n = 1'b0;
        gnt1_n = 1'b0;
        en_n = 1'b0;
        x_n = oUPDATE_X;
        y_n = oUPDATE_Y;
        data_n = oUPDATE_DATA;
        if (state == IDLE && iCLEAR) begin
            state_n = CLEAR;
            clr_n = iCLEAR_DATA;
            cx_n = 7'd0;
            cy_n = 6'd0;
        end else if (state == IDLE && (e0 | e1)) begin
            // ptr=1 means R0 was granted last, so R1 wins a tie
            gnt0_n = e0 & (~e1 | ~ptr);
            gnt1_n = ~gnt0_n;
            ptr_n = gnt0_n;
            x_n = gnt0_n ? iX0 : iX1;
            y_n = gnt0_n ? iY0 : iY1;
            data_n = gnt0_n ? iD0 : iD1;
            en_n = (x_n < 7'(GRID_W)) && (y_n < 6'(GRID_H));
        end else if (state == CLEAR && slot) begin
            en_n = 1'b1;
            x_n = cx;
            y_n = cy;
            data_n = clr;
            cx_n = row_end ? 7'd0 : cx + 7'd1;
            cy_n = row_end ? cy + 6'd1 : cy;
            state_n = (row_end && cy == 6'(GRID_H - 1)) ? FINISH : CLEAR;
        end else if (state == FINISH) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
            cx <= 7'd0;
            cy <= 6'd0;
            clr <= 12'd0;
            ptr <= 1'b0;
            oGNT0 <= 1'b0;
            oGNT1 <= 1'b0;
            oUPDATE_EN <= 1'b0;
            oUPDATE_X <= 7'd0;
            oUPDATE_Y <= 6'd0;
            oUPDATE_DATA <= 12'd0;
            oBUSY <= 1'b0;
            oCLEAR_DONE <= 1'b0;
        end else begin
            state <= state_n;
            cx <= cx_n;
            cy <= cy_n;
            clr <= clr_n;
            ptr <= ptr_n;
            oGNT0 <= gnt0_n;
            oGNT1 <= gnt1_n;
            oUPDATE_EN <= en_n;
            oUPDATE_X <= x_n;
            oUPDATE_Y <= y_n;
            oUPDATE_DATA <= data_n;
            oBUSY <= state_n != IDLE;
            oCLEAR_DONE <= state == FINISH;
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed stimulus, cycle-level reference model and literal spot checks.
module tb_fb_write_scheduler;
    localparam int GW = 20;
    localparam int GH = 15;
`ifdef VBLANK_ONLY_EN
    localparam bit VB = 1'b1;
`else
    localparam bit VB = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b1, req0 = 1'b0, req1 = 1'b0, clear = 1'b0, vblank = 1'b1;
    logic [6:0] x0 = '0, x1 = '0;
    logic [5:0] y0 = '0, y1 = '0;
    logic [11:0] d0 = '0, d1 = '0, cdata = '0;
    logic gnt0, gnt1, en, busy, done;
    logic [6:0] ux;
    logic [5:0] uy;
    logic [11:0] ud;
    int checks = 0, errors = 0;
    bit mon_on = 1'b0;

    fb_write_scheduler #(.GRID_W(GW), .GRID_H(GH)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iREQ0(req0), .iREQ1(req1),
        .iX0(x0), .iX1(x1), .iY0(y0), .iY1(y1), .iD0(d0), .iD1(d1),
        .iCLEAR(clear), .iCLEAR_DATA(cdata), .iVBLANK(vblank),
        .oGNT0(gnt0), .oGNT1(gnt1), .oUPDATE_EN(en), .oUPDATE_X(ux),
        .oUPDATE_Y(uy), .oUPDATE_DATA(ud), .oBUSY(busy), .oCLEAR_DONE(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clear progress is a write index k, cell = (k % GW, k / GW).
    bit exp_gnt0, exp_gnt1, exp_en, exp_busy, exp_done;
    bit [6:0] exp_x;
    bit [5:0] exp_y;
    bit [11:0] exp_data, m_col;
    bit m_ok, m_e0, m_e1, m_pick1, m_last_r0;
    int k = 0, phase = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {exp_gnt0, exp_gnt1, exp_en, exp_busy, exp_done} = '0;
            exp_x = '0;
            exp_y = '0;
            exp_data = '0;
            m_last_r0 = 1'b0;
            k = 0;
            phase = 0;
        end else begin
            m_ok = !VB || vblank;
            m_e0 = req0 && !exp_gnt0 && m_ok;
            m_e1 = req1 && !exp_gnt1 && m_ok;
            {exp_gnt0, exp_gnt1, exp_en, exp_done} = '0;
            if (phase == 2) begin
                phase = 0;
                exp_done = 1'b1;
            end else if (phase == 1) begin
                if (m_ok) begin
                    exp_en = 1'b1;
                    exp_x = 7'(k % GW);
                    exp_y = 6'(k / GW);
                    exp_data = m_col;
                    k++;
                    if (k == GW * GH) phase = 2;
                end
            end else if (clear) begin
                phase = 1;
                k = 0;
                m_col = cdata;
            end else if (m_e0 || m_e1) begin
                m_pick1 = !(m_e0 && (!m_e1 || !m_last_r0));
                exp_gnt0 = !m_pick1;
                exp_gnt1 = m_pick1;
                m_last_r0 = !m_pick1;
                exp_x = m_pick1 ? x1 : x0;
                exp_y = m_pick1 ? y1 : y0;
                exp_data = m_pick1 ? d1 : d0;
                exp_en = exp_x < GW && exp_y < GH;
            end
            exp_busy = phase != 0;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("gnt0", gnt0, exp_gnt0);
            check("gnt1", gnt1, exp_gnt1);
            check("update_en", en, exp_en);
            check("busy", busy, exp_busy);
            check("clear_done", done, exp_done);
            if (exp_en) begin
                check("update_x", ux, exp_x);
                check("update_y", uy, exp_y);
                check("update_data", ud, exp_data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int writes, bad, g1busy;
    bit seen, pulsed;
    logic [3:0] g0s, g1s;

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_gnt0", gnt0, 0);
        check("rst_en", en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        // R0 alone held for four edges
        x0 = 7'd3; y0 = 6'd5; d0 = 12'h00F; req0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g0s[i] = gnt0;
            if (i == 0) begin
                check("t1_x", ux, 3);
                check("t1_y", uy, 5);
                check("t1_data", ud, 12'h00F);
                check("t1_en", en, 1);
            end
        end
        req0 = 1'b0;
        check("t1_gnt_pattern", g0s, 4'b0101);
        // both requesters held after reset
        do_reset();
        x0 = 7'd1; y0 = 6'd1; d0 = 12'h111; x1 = 7'd4; y1 = 6'd7; d1 = 12'h222;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g0s[i] = gnt0;
            g1s[i] = gnt1;
            if (i == 1) check("t2_data_r1", ud, 12'h222);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t2_gnt0_pattern", g0s, 4'b0101);
        check("t2_gnt1_pattern", g1s, 4'b1010);
        // clear with R1 waiting
        @(negedge clk);
        x1 = 7'd2; y1 = 6'd2; d1 = 12'h123; req1 = 1'b1;
        clear = 1'b1; cdata = 12'hFFF;
        writes = 0; seen = 1'b0; g1busy = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            clear = 1'b0;
            if (en) writes++;
            if (gnt1 && busy) g1busy++;
            if (done) seen = 1'b1;
        end
        check("t3_writes", writes, 300);
        check("t3_done_seen", seen, 1);
        check("t3_grant_while_busy", g1busy, 0);
        @(negedge clk);
        check("t3_r1_after_clear", gnt1, 1);
        req1 = 1'b0;
        // second iCLEAR mid-sweep is ignored
        @(negedge clk);
        clear = 1'b1; cdata = 12'h5A5;
        writes = 0; seen = 1'b0; bad = 0; pulsed = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            clear = 1'b0;
            if (en) writes++;
            if (en && ud != 12'h5A5) bad++;
            if (done) seen = 1'b1;
            if (writes == 100 && !pulsed) begin
                clear = 1'b1; cdata = 12'h0A5; pulsed = 1'b1;
            end
        end
        check("t4_writes", writes, 300);
        check("t4_done_seen", seen, 1);
        check("t4_colour_changed", bad, 0);
        // reset in the middle of a sweep
        @(negedge clk);
        clear = 1'b1; cdata = 12'h777;
        writes = 0;
        for (int i = 0; i < 200 && writes < 50; i++) begin
            @(negedge clk);
            clear = 1'b0;
            if (en) writes++;
        end
        check("t5_reached_50", writes, 50);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_en", en, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_x", ux, 0);
        check("t5_async_data", ud, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst_n = 1'b1;
        check("t5_no_done", seen, 0);
        clear = 1'b1; cdata = 12'h3C3;
        @(negedge clk);
        clear = 1'b0;
        check("t5_busy_after_start", busy, 1);
        @(negedge clk);
        check("t5_first_en", en, 1);
        check("t5_first_x", ux, 0);
        check("t5_first_y", uy, 0);
        check("t5_first_data", ud, 12'h3C3);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("t5_restart_done", seen, 1);
        // vblank gating, then an out-of-range request
        @(negedge clk);
        clear = 1'b1; cdata = 12'h0F0;
        writes = 0; seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            clear = 1'b0;
            vblank = ((i / 10) % 2) == 0;
            if (en) writes++;
            if (done) seen = 1'b1;
        end
        check("t6_writes", writes, 300);
        check("t6_done_seen", seen, 1);
        vblank = 1'b1;
        x0 = 7'd25; y0 = 6'd3; d0 = 12'hABC; req0 = 1'b1;
        @(negedge clk);
        check("t6_oor_gnt0", gnt0, 1);
        check("t6_oor_en", en, 0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
